// File: rtl/connect4_board_rx.sv
// Receive side of the Connect4 board link: synchronizes the three link pins, deserializes a
// 92-bit frame, checks structure and game legality, and publishes clean boards.
module connect4_board_rx #(
    parameter int unsigned ROWS        = 6,
    parameter int unsigned COLS        = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   link_sclk,
    input  logic                   link_sdata,
    input  logic                   link_frame,
    output logic [ROWS*COLS-1:0]   board_p1,
    output logic [ROWS*COLS-1:0]   board_p2,
    output logic                   frame_valid,
    output logic                   frame_error,
    output logic [4:0]             err_cause,
    output logic                   busy
);

    localparam int unsigned CELLS      = ROWS * COLS;
    localparam int unsigned FRAME_BITS = 2 * CELLS + 8;
    localparam int unsigned CNT_MAX    = FRAME_BITS + 1;
    localparam int unsigned CW         = $clog2(CNT_MAX + 1);
    localparam int unsigned NW         = $clog2(CELLS + 1);

    typedef enum logic [1:0] {
        StWaitIdle,
        StIdle,
        StShift,
        StCheck
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, sdata_sync, frame_sync;
    logic sclk_prev, frame_prev;
    logic sclk_rise_q, frame_rise_q, frame_fall_q, frame_lvl_q, data_q;

    logic [CW-1:0]         cnt_q;
    logic [FRAME_BITS-1:0] sr_q;

    logic [CELLS-1:0] p1_map, p2_map, occ_map;
    logic [NW-1:0]    n1, n2;
    logic             code_err, grav_err, csum_err, count_err, len_err;
    logic [4:0]       errs;

    // Synchronizers and edge detectors are left unreset so a frame in flight at reset stays
    // visible as "frame high", which keeps WAIT_IDLE from mistaking it for a new frame.
    always_ff @(posedge clk) begin
        sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], link_sclk};
        sdata_sync   <= {sdata_sync[SYNC_STAGES-2:0], link_sdata};
        frame_sync   <= {frame_sync[SYNC_STAGES-2:0], link_frame};
        sclk_prev    <= sclk_sync[SYNC_STAGES-1];
        frame_prev   <= frame_sync[SYNC_STAGES-1];
        sclk_rise_q  <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
        frame_rise_q <= frame_sync[SYNC_STAGES-1] & ~frame_prev;
        frame_fall_q <= ~frame_sync[SYNC_STAGES-1] & frame_prev;
        frame_lvl_q  <= frame_sync[SYNC_STAGES-1];
        data_q       <= sdata_sync[SYNC_STAGES-1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitIdle: if (!frame_lvl_q) state_d = StIdle;
            StIdle:     if (frame_rise_q) state_d = StShift;
            StShift:    if (frame_fall_q) state_d = StCheck;
            StCheck:    state_d = StIdle;
            default:    state_d = StWaitIdle;
        endcase
    end

    always_comb begin
        p1_map   = '0;
        p2_map   = '0;
        occ_map  = '0;
        n1       = '0;
        n2       = '0;
        code_err = 1'b0;
        grav_err = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            p1_map[i]  = (sr_q[2*i +: 2] == 2'b01);
            p2_map[i]  = (sr_q[2*i +: 2] == 2'b10);
            occ_map[i] = (sr_q[2*i +: 2] != 2'b00);
            code_err   = code_err | (sr_q[2*i +: 2] == 2'b11);
            n1         = n1 + NW'(p1_map[i]);
            n2         = n2 + NW'(p2_map[i]);
        end
        for (int i = COLS; i < CELLS; i++) begin
            grav_err = grav_err | (occ_map[i] & ~occ_map[i-COLS]);
        end
        csum_err  = sr_q[FRAME_BITS-1 -: 8] != (8'(n1) + 8'(n2));
        count_err = !((n1 == n2) || (n1 == n2 + NW'(1)));
        len_err   = cnt_q != CW'(FRAME_BITS);
        errs      = {count_err, csum_err, grav_err, code_err, len_err};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWaitIdle;
            cnt_q       <= '0;
            sr_q        <= '0;
            board_p1    <= '0;
            board_p2    <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            err_cause   <= '0;
        end else begin
            state_q     <= state_d;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (frame_rise_q) begin
                        cnt_q <= '0;
                        sr_q  <= '0;
                    end
                end
                StShift: begin
                    // frame_lvl_q is already low on the falling-edge cycle, so a
                    // coincident strobe is dropped here.
                    if (sclk_rise_q && frame_lvl_q) begin
                        sr_q <= {data_q, sr_q[FRAME_BITS-1:1]};
                        if (cnt_q != CW'(CNT_MAX)) cnt_q <= cnt_q + CW'(1);
                    end
                end
                StCheck: begin
                    if (errs == 5'b0) begin
                        board_p1    <= p1_map;
                        board_p2    <= p2_map;
                        frame_valid <= 1'b1;
                    end else begin
                        err_cause   <= errs;
                        frame_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == StShift) || (state_q == StCheck);

endmodule

// File: tb/tb_connect4_board_rx.sv
// Scoreboard bench for connect4_board_rx: random and directed frames are modelled from the
// game rules on a cell array; a negedge monitor pops and checks every published result.
module tb_connect4_board_rx;

    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        link_sclk = 1'b0, link_sdata = 1'b0, link_frame = 1'b0;
    logic [41:0] board_p1, board_p2;
    logic        frame_valid, frame_error, busy;
    logic [4:0]  err_cause;

    connect4_board_rx #(.ROWS(6), .COLS(7), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .link_sclk(link_sclk), .link_sdata(link_sdata),
        .link_frame(link_frame), .board_p1(board_p1), .board_p2(board_p2),
        .frame_valid(frame_valid), .frame_error(frame_error), .err_cause(err_cause), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ok;
        logic [41:0] p1;
        logic [41:0] p2;
        logic [4:0]  cause;
        int          fall_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, failures = 0, pulses = 0, cyc = 0;

    logic [1:0]  cells[42];
    int          heights[7];
    logic [7:0]  csum;
    logic [41:0] mdl_p1 = '0, mdl_p2 = '0;
    logic [4:0]  mdl_cause = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_valid || frame_error) begin
            chk("pulse_exclusive", 64'(frame_valid & frame_error), 0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: valid=%0d error=%0d, none expected",
                         frame_valid, frame_error);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind_valid", 64'(frame_valid), 64'(mon_e.ok));
                chk("board_p1", 64'(board_p1), 64'(mon_e.p1));
                chk("board_p2", 64'(board_p2), 64'(mon_e.p2));
                chk("err_cause", 64'(err_cause), 64'(mon_e.cause));
                chk("busy_at_pulse", 64'(busy), 0);
                chk("latency", 64'(cyc - mon_e.fall_cyc), 64'(SYNC_STAGES + 3));
                pulses++;
            end
        end
    end

    task automatic clear_board();
        for (int i = 0; i < 42; i++) cells[i] = 2'b00;
        for (int c = 0; c < 7; c++) heights[c] = 0;
        csum = 8'd0;
    endtask

    task automatic drop(input int col, input logic [1:0] player);
        cells[heights[col]*7 + col] = player;
        heights[col]++;
        csum = csum + 8'd1;
    endtask

    // Expected outcome straight from the game rules on the cell array.
    task automatic model_push(input int nbits);
        exp_t e;
        int n1 = 0, n2 = 0;
        bit code = 0, grav = 0;
        logic [4:0] c;
        for (int i = 0; i < 42; i++) begin
            if (cells[i] == 2'b01) n1++;
            else if (cells[i] == 2'b10) n2++;
            else if (cells[i] == 2'b11) code = 1;
        end
        for (int r = 1; r < 6; r++)
            for (int col = 0; col < 7; col++)
                if (cells[r*7+col] != 2'b00 && cells[(r-1)*7+col] == 2'b00) grav = 1;
        c[0] = (nbits != 92);
        c[1] = code;
        c[2] = grav;
        c[3] = (csum != 8'(n1 + n2));
        c[4] = !(n1 == n2 || n1 == n2 + 1);
        if (c == 5'b0) begin
            e.ok = 1;
            for (int i = 0; i < 42; i++) begin
                mdl_p1[i] = (cells[i] == 2'b01);
                mdl_p2[i] = (cells[i] == 2'b10);
            end
        end else begin
            e.ok = 0;
            mdl_cause = c;
        end
        e.p1 = mdl_p1;
        e.p2 = mdl_p2;
        e.cause = mdl_cause;
        e.fall_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        link_sdata = b;
        repeat (4) @(posedge clk);
        #1 link_sclk = 1'b1;
        repeat (4) @(posedge clk);
        #1 link_sclk = 1'b0;
    endtask

    task automatic send_frame(input int nbits, input int abort_at);
        logic [127:0] bits;
        int target;
        bit aborted = 0;
        bits = '0;
        for (int i = 0; i < 42; i++) bits[2*i +: 2] = cells[i];
        bits[84 +: 8] = csum;
        @(posedge clk);
        #1 link_frame = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < nbits; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                mdl_p1 = '0;
                mdl_p2 = '0;
                mdl_cause = '0;
                aborted = 1;
                chk("abort_p1_zero", 64'(board_p1), 0);
                chk("abort_p2_zero", 64'(board_p2), 0);
                chk("abort_cause_zero", 64'(err_cause), 0);
                chk("abort_busy_zero", 64'(busy), 0);
            end
            send_bit(bits[k]);
            if (k == 8 && !aborted) chk("busy_in_frame", 64'(busy), 1);
        end
        repeat (4) @(posedge clk);
        #1 link_frame = 1'b0;
        link_sdata = 1'b0;
        target = pulses + (aborted ? 0 : 1);
        if (aborted) begin
            repeat (30) @(posedge clk);
            #1 chk("no_pulse_after_abort", 64'(pulses), 64'(target));
        end else begin
            model_push(nbits);
            for (int w = 0; w < 40 && pulses < target; w++) @(posedge clk);
            #1;
            if (pulses < target) begin
                checks++;
                failures++;
                $display("FAIL pulse_timeout: got %0d pulses expected %0d", pulses, target);
            end
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic gen_legal(input int moves);
        int col;
        clear_board();
        for (int m = 0; m < moves; m++) begin
            col = $urandom_range(0, 6);
            while (heights[col] >= 6) col = (col + 1) % 7;
            drop(col, (m % 2 == 0) ? 2'b01 : 2'b10);
        end
    endtask

    initial begin
        int kind, idx, off, col;
        repeat (8) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_p1", 64'(board_p1), 0);
        chk("reset_p2", 64'(board_p2), 0);
        chk("reset_valid", 64'(frame_valid), 0);
        chk("reset_error", 64'(frame_error), 0);
        chk("reset_cause", 64'(err_cause), 0);
        chk("reset_busy", 64'(busy), 0);

        clear_board();
        send_frame(92, -1);
        chk("empty_cause", 64'(err_cause), 0);

        clear_board();
        cells[3] = 2'b01;
        csum = 8'd1;
        send_frame(92, -1);
        chk("single_p1", 64'(board_p1), 64'h8);

        clear_board();
        cells[10] = 2'b01;
        csum = 8'd1;
        send_frame(92, -1);
        chk("floating_cause", 64'(err_cause), 64'b00100);
        chk("floating_hold_p1", 64'(board_p1), 64'h8);

        clear_board();
        send_frame(60, -1);
        chk("short_cause", 64'(err_cause), 64'b00001);

        clear_board();
        cells[0] = 2'b11;
        cells[1] = 2'b10;
        csum = 8'd1;
        send_frame(92, -1);
        chk("code_count_cause", 64'(err_cause), 64'b10010);

        clear_board();
        for (int r = 0; r < 4; r++) begin
            drop(0, 2'b01);
            drop(1, 2'b10);
        end
        send_frame(92, -1);
        clear_board();
        send_frame(93, -1);
        chk("long_cause", 64'(err_cause), 64'b00001);

        gen_legal(9);
        send_frame(92, 40);
        gen_legal(5);
        send_frame(92, -1);

        for (int t = 0; t < 16; t++) begin
            gen_legal($urandom_range(0, 42));
            kind = $urandom_range(0, 4);
            case (kind)
                1: csum = csum + 8'($urandom_range(1, 255));
                2: begin
                    off = $urandom_range(0, 6);
                    for (int s = 0; s < 7; s++) begin
                        col = (off + s) % 7;
                        if (heights[col] <= 4) begin
                            cells[35 + col] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                            csum = csum + 8'd1;
                            break;
                        end
                    end
                end
                3: if (csum != 8'd0) begin
                    idx = $urandom_range(0, 41);
                    while (cells[idx] == 2'b00) idx = (idx + 1) % 42;
                    cells[idx] = (cells[idx] == 2'b01) ? 2'b10 : 2'b01;
                end
                4: if (csum < 8'd42) begin
                    col = $urandom_range(0, 6);
                    while (heights[col] >= 6) col = (col + 1) % 7;
                    drop(col, 2'b10);
                end
                default: ;
            endcase
            send_frame(92, -1);
        end

        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/connect4_board_rx.md
Name: connect4_board_rx

Overview:
- Receive end of the board link: deserializes a Connect4 board frame arriving on three slow external pins (strobe clock, data, frame enable) and reconstructs two per-player occupancy maps.
- Checks each frame for structure and game legality. Publishes the board only when the frame is clean.
- Sits beside the board-to-pin driver path, so a second board or a test fixture can push a complete game state into the design.

Parameters:
- ROWS, 6, board rows (row 0 = bottom).
- COLS, 7, board columns.
- SYNC_STAGES, 2, synchronizer flops on each link input (minimum 2).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- link_sclk, input, 1, asynchronous serial bit strobe; data is sampled on its rising edge.
- link_sdata, input, 1, asynchronous serial data.
- link_frame, input, 1, asynchronous frame enable, high for the whole frame.
- board_p1, output, ROWS*COLS (42), player-1 occupancy; bit i = row*COLS+col.
- board_p2, output, ROWS*COLS (42), player-2 occupancy.
- frame_valid, output, 1, one-cycle pulse when a good frame is published.
- frame_error, output, 1, one-cycle pulse when a frame is rejected.
- err_cause, output, 5, sticky cause of the last rejected frame: [0] LEN, [1] CODE, [2] GRAVITY, [3] CSUM, [4] COUNT.
- busy, output, 1, high from frame start until the frame result is posted.

Behaviour:
- Reset and clock:
  - One clock domain and one reset. rst is synchronous and active-high.
  - Reset values: board_p1=0, board_p2=0, frame_valid=0, frame_error=0, err_cause=0, busy=0. Bit counter and shift register are cleared.
- Input synchronization and sampling:
  - All three link inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized copies.
  - A bit is sampled only on a synchronized sclk rising edge in a cycle where synchronized frame is high.
  - Sender constraint: each sclk high and low phase is at least SYNC_STAGES+1 clk cycles.
- Frame format (LSB first):
  - 92 bits total. Bits 2i and 2i+1 carry the 2-bit code for cell i (i=0..41), LSB first.
  - Cell codes: 00 empty, 01 player 1, 10 player 2, 11 illegal.
  - Bits 84..91 carry an 8-bit checksum equal to the number of occupied cells.
- States: WAIT_IDLE, IDLE, SHIFT, CHECK.
  - After rst, the FSM enters WAIT_IDLE. It stays there until synchronized frame is low, so a frame already in progress at reset is discarded. It then goes to IDLE.
  - IDLE -> SHIFT on a synchronized frame rising edge. The counter is cleared and busy goes high that cycle.
  - SHIFT: each sampled bit shifts in and the counter increments, saturating at 93. On a synchronized frame falling edge, go to CHECK.
  - CHECK (1 cycle): evaluate all checks in parallel, register the results, then return to IDLE.
- Checks (all evaluated; err_cause records every failing check):
  - LEN: bit count != 92. Covers both short and long frames.
  - CODE: any cell has code 11.
  - GRAVITY: any occupied cell i with i >= COLS whose cell i-COLS is empty.
  - CSUM: the received checksum != n1+n2, where n1 and n2 are the 6-bit occupied-cell counts for each player.
  - COUNT: the board is legal only if n1 == n2 or n1 == n2+1 (player 1 moves first). Anything else sets COUNT.
- Result, on the cycle after CHECK:
  - Pass: board outputs load the new maps, frame_valid=1 for exactly one cycle, err_cause unchanged.
  - Fail: board outputs hold their previous values, frame_error=1 for exactly one cycle, err_cause is overwritten.
  - busy drops in the same cycle as the pulse.
  - frame_valid and frame_error are never high together.
- Latency: the pulse appears SYNC_STAGES+3 clk cycles after the raw link_frame falls.
- Simultaneous events:
  - A sclk edge in the same synchronized cycle as the frame falling edge is not sampled.
  - A frame rising edge while in CHECK is ignored. The sender must keep frame low for at least 4 clk cycles between frames.
- rst in any state aborts the frame with no pulse and enters WAIT_IDLE.

Test Plan:
- Empty board: 84 zero bits plus checksum 0x00 -> frame_valid pulse; board_p1=0, board_p2=0; err_cause=0.
- Single move: cell 3 = 01, checksum 0x01 -> board_p1 = 42'h8, board_p2 = 0; pulse at SYNC_STAGES+3 cycles after frame falls.
- Floating piece: cell 10 = 01, cell 3 empty, checksum 0x01 -> frame_error; err_cause = 5'b00100; boards keep the previous frame's values.
- Short frame of 60 bits, then a separate frame with cell 0 = 11 and p2 count 1 vs p1 count 0 -> first gives err_cause = 5'b00001. Second gives CODE and COUNT set, with CSUM set if the checksum mismatches.
- Eight-move legal board (n1 = n2 = 4, stacked in columns 0 and 1), checksum 0x08 -> exact 42-bit maps match the model; then a 93-bit frame -> LEN error with boards unchanged.
- rst asserted at bit 40 with frame still high -> outputs 0, no pulse; the rest of that frame is ignored; the next full frame is accepted.
